// File: rtl/bcd_down_timer.sv
// Two-digit BCD down-counter with load, synchronous clear, hold-or-reload at 00,
// a three-state expiry FSM, and a borrow output for cascading stages.
module bcd_down_timer #(
  parameter int AUTO_RELOAD = 0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       clrn,
  input  logic       load,
  input  logic       cnt_en,
  input  logic [7:0] I,
  output logic [7:0] count,
  output logic       borrow,
  output logic       zero,
  output logic       done,
  output logic       busy,
  output logic       expired,
  output logic       bcd_err
);

  localparam bit RELOAD = (AUTO_RELOAD != 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] count_q, count_nxt;
  logic [7:0] reload_q, reload_nxt;
  logic       done_q, done_nxt;
  logic       busy_q, expired_q;
  logic       bcd_err_q, bcd_err_nxt;
  logic       dec_req;
  logic [7:0] load_val;
  logic       load_bad;

  function automatic logic [3:0] sat_digit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // Only called with a non-zero, valid BCD value.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] != 4'd0)
      return {v[7:4], v[3:0] - 4'd1};
    else
      return {v[7:4] - 4'd1, 4'd9};
  endfunction

  assign load_val = {sat_digit(I[7:4]), sat_digit(I[3:0])};
  assign load_bad = (I[7:4] > 4'd9) || (I[3:0] > 4'd9);
  assign dec_req  = cnt_en && !load && clrn;

  assign zero    = (count_q == 8'h00);
  assign borrow  = zero && dec_req;
  assign count   = count_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign expired = expired_q;
  assign bcd_err = bcd_err_q;

  always_comb begin
    state_nxt   = state;
    count_nxt   = count_q;
    reload_nxt  = reload_q;
    done_nxt    = 1'b0;
    bcd_err_nxt = bcd_err_q;
    if (!clrn) begin
      state_nxt   = IDLE;
      count_nxt   = 8'h00;
      reload_nxt  = 8'h00;
      bcd_err_nxt = 1'b0;
    end else if (load) begin
      count_nxt   = load_val;
      reload_nxt  = load_val;
      bcd_err_nxt = bcd_err_q || load_bad;
      state_nxt   = (load_val != 8'h00) ? ACTIVE : IDLE;
    end else if (cnt_en) begin
      if (zero) begin
        if (RELOAD)
          count_nxt = reload_q;
      end else begin
        count_nxt = bcd_dec(count_q);
        if (count_q == 8'h01) begin
          done_nxt = 1'b1;
          if (!RELOAD && state == ACTIVE)
            state_nxt = EXPIRED;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      count_q   <= 8'h00;
      reload_q  <= 8'h00;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      expired_q <= 1'b0;
      bcd_err_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      count_q   <= count_nxt;
      reload_q  <= reload_nxt;
      done_q    <= done_nxt;
      busy_q    <= (state_nxt == ACTIVE);
      expired_q <= (state_nxt == EXPIRED);
      bcd_err_q <= bcd_err_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_down_timer.sv
// Bench for bcd_down_timer: a hold-mode unit, plus a reload-mode lower stage
// cascading via borrow into a hold-mode upper stage, checked against an integer model.
module tb_bcd_down_timer;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       clrn_v [3];
  logic       load_v [3];
  logic       en_v   [2];
  logic [7:0] i_v    [3];
  logic [7:0] cnt_o  [3];
  logic       borrow_o [3];
  logic       zero_o   [3];
  logic       done_o   [3];
  logic       busy_o   [3];
  logic       exp_o    [3];
  logic       err_o    [3];

  int checks = 0;
  int errors = 0;

  // Model: decimal value 0..99, stored load value, state 0=idle 1=active 2=expired.
  int m_cnt [3];
  int m_rld [3];
  int m_st  [3];
  bit m_done[3];
  bit m_err [3];

  always #5 clk = ~clk;

  bcd_down_timer #(.AUTO_RELOAD(0)) u_a (
    .clk(clk), .rstn(rstn), .clrn(clrn_v[0]), .load(load_v[0]), .cnt_en(en_v[0]),
    .I(i_v[0]), .count(cnt_o[0]), .borrow(borrow_o[0]), .zero(zero_o[0]),
    .done(done_o[0]), .busy(busy_o[0]), .expired(exp_o[0]), .bcd_err(err_o[0]));

  bcd_down_timer #(.AUTO_RELOAD(1)) u_lo (
    .clk(clk), .rstn(rstn), .clrn(clrn_v[1]), .load(load_v[1]), .cnt_en(en_v[1]),
    .I(i_v[1]), .count(cnt_o[1]), .borrow(borrow_o[1]), .zero(zero_o[1]),
    .done(done_o[1]), .busy(busy_o[1]), .expired(exp_o[1]), .bcd_err(err_o[1]));

  bcd_down_timer #(.AUTO_RELOAD(0)) u_hi (
    .clk(clk), .rstn(rstn), .clrn(clrn_v[2]), .load(load_v[2]), .cnt_en(borrow_o[1]),
    .I(i_v[2]), .count(cnt_o[2]), .borrow(borrow_o[2]), .zero(zero_o[2]),
    .done(done_o[2]), .busy(busy_o[2]), .expired(exp_o[2]), .bcd_err(err_o[2]));

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at %0t: got %h expected %h", nm, idx, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t, o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  function automatic bit exp_borrow(input int i, input bit en);
    return (m_cnt[i] == 0) && en && !load_v[i] && clrn_v[i];
  endfunction

  function automatic bit en_of(input int i);
    return (i == 2) ? exp_borrow(1, en_v[1]) : en_v[i];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_rld[i] = 0; m_st[i] = 0; m_done[i] = 0; m_err[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input bit en);
    int t, o, v;
    if (!clrn_v[i]) begin
      m_cnt[i] = 0; m_rld[i] = 0; m_st[i] = 0; m_done[i] = 0; m_err[i] = 0;
    end else if (load_v[i]) begin
      t = int'(i_v[i][7:4]);
      o = int'(i_v[i][3:0]);
      if (t > 9 || o > 9) m_err[i] = 1;
      if (t > 9) t = 9;
      if (o > 9) o = 9;
      v = t * 10 + o;
      m_cnt[i] = v;
      m_rld[i] = v;
      m_st[i] = (v != 0) ? 1 : 0;
      m_done[i] = 0;
    end else if (en) begin
      if (m_cnt[i] == 0) begin
        m_done[i] = 0;
        if (i == 1) m_cnt[i] = m_rld[i];
      end else begin
        m_done[i] = (m_cnt[i] == 1);
        m_cnt[i] = m_cnt[i] - 1;
        if (m_cnt[i] == 0 && i != 1) m_st[i] = 2;
      end
    end else begin
      m_done[i] = 0;
    end
  endtask

  // Advance one edge; the model samples the same inputs the DUT sees at that edge.
  task automatic tick();
    bit bl;
    @(posedge clk);
    if (rstn) begin
      bl = exp_borrow(1, en_v[1]);
      model_step(0, en_v[0]);
      model_step(1, en_v[1]);
      model_step(2, bl);
    end
    #1;
  endtask

  task automatic set_in(input int i, input bit c, input bit l, input bit e, input logic [7:0] v);
    clrn_v[i] = c;
    load_v[i] = l;
    i_v[i] = v;
    if (i < 2) en_v[i] = e;
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk("count",   i, cnt_o[i],    to_bcd(m_cnt[i]));
      chk("zero",    i, zero_o[i],   8'(m_cnt[i] == 0));
      chk("borrow",  i, borrow_o[i], 8'(exp_borrow(i, en_of(i))));
      chk("done",    i, done_o[i],   8'(m_done[i]));
      chk("busy",    i, busy_o[i],   8'(m_st[i] == 1));
      chk("expired", i, exp_o[i],    8'(m_st[i] == 2));
      chk("bcd_err", i, err_o[i],    8'(m_err[i]));
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) set_in(i, 1'b1, 1'b0, 1'b0, 8'h00);
    model_reset();
    rstn = 1'b0;
    repeat (2) tick();
    chk("rst_count", 0, cnt_o[0], 8'h00);
    chk("rst_busy", 0, busy_o[0], 8'h00);
    chk("rst_expired", 0, exp_o[0], 8'h00);
    chk("rst_err", 0, err_o[0], 8'h00);
    chk("rst_done", 0, done_o[0], 8'h00);
    rstn = 1'b1;

    // Load 12 and count down to a held 00.
    set_in(0, 1'b1, 1'b1, 1'b0, 8'h12);
    tick();
    chk("ld12", 0, cnt_o[0], 8'h12);
    chk("ld12_busy", 0, busy_o[0], 8'h01);
    set_in(0, 1'b1, 1'b0, 1'b1, 8'h00);
    repeat (11) tick();
    chk("at01", 0, cnt_o[0], 8'h01);
    chk("at01_done", 0, done_o[0], 8'h00);
    tick();
    chk("at00", 0, cnt_o[0], 8'h00);
    chk("at00_done", 0, done_o[0], 8'h01);
    chk("at00_expired", 0, exp_o[0], 8'h01);
    chk("at00_busy", 0, busy_o[0], 8'h00);
    chk("at00_borrow", 0, borrow_o[0], 8'h01);
    tick();
    chk("hold00", 0, cnt_o[0], 8'h00);
    chk("hold00_done", 0, done_o[0], 8'h00);
    set_in(0, 1'b1, 1'b0, 1'b0, 8'h00);

    // Reload mode: 03 -> 02, 01, 00, 03.
    set_in(1, 1'b1, 1'b1, 1'b0, 8'h03);
    tick();
    set_in(1, 1'b1, 1'b0, 1'b1, 8'h00);
    repeat (3) tick();
    chk("ar_00", 1, cnt_o[1], 8'h00);
    chk("ar_done", 1, done_o[1], 8'h01);
    chk("ar_busy", 1, busy_o[1], 8'h01);
    chk("ar_borrow", 1, borrow_o[1], 8'h01);
    tick();
    chk("ar_reload", 1, cnt_o[1], 8'h03);
    chk("ar_done2", 1, done_o[1], 8'h00);
    chk("ar_borrow2", 1, borrow_o[1], 8'h00);
    set_in(1, 1'b1, 1'b0, 1'b0, 8'h00);

    // Load beats decrement; clear beats load.
    set_in(0, 1'b1, 1'b1, 1'b0, 8'h27);
    tick();
    set_in(0, 1'b1, 1'b1, 1'b1, 8'h50);
    tick();
    chk("ld_over_en", 0, cnt_o[0], 8'h50);
    set_in(0, 1'b0, 1'b1, 1'b0, 8'h33);
    tick();
    chk("clr_over_ld", 0, cnt_o[0], 8'h00);
    chk("clr_busy", 0, busy_o[0], 8'h00);

    // Invalid digit saturates and sets the sticky error.
    set_in(0, 1'b1, 1'b1, 1'b0, 8'hA7);
    tick();
    chk("sat97", 0, cnt_o[0], 8'h97);
    chk("sat_err", 0, err_o[0], 8'h01);
    set_in(0, 1'b1, 1'b0, 1'b1, 8'h00);
    repeat (3) tick();
    chk("sat94", 0, cnt_o[0], 8'h94);
    chk("err_sticky", 0, err_o[0], 8'h01);
    set_in(0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    chk("err_clr", 0, err_o[0], 8'h00);

    // Asynchronous reset in the middle of a count.
    set_in(0, 1'b1, 1'b1, 1'b0, 8'h45);
    tick();
    set_in(0, 1'b1, 1'b0, 1'b1, 8'h00);
    repeat (2) tick();
    chk("pre_rst", 0, cnt_o[0], 8'h43);
    #2 rstn = 1'b0;
    model_reset();
    #1;
    chk("async_count", 0, cnt_o[0], 8'h00);
    chk("async_busy", 0, busy_o[0], 8'h00);
    tick();
    rstn = 1'b1;
    tick();
    chk("post_rst_done", 0, done_o[0], 8'h00);
    chk("post_rst_count", 0, cnt_o[0], 8'h00);
    set_in(0, 1'b1, 1'b0, 1'b0, 8'h00);

    // Cascade: lower reloads 01, upper counts 02 down on lower borrows.
    set_in(1, 1'b1, 1'b1, 1'b0, 8'h01);
    set_in(2, 1'b1, 1'b1, 1'b0, 8'h02);
    tick();
    set_in(1, 1'b1, 1'b0, 1'b1, 8'h00);
    set_in(2, 1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    chk("casc_lo0", 1, cnt_o[1], 8'h00);
    chk("casc_hi2", 2, cnt_o[2], 8'h02);
    tick();
    chk("casc_lo1", 1, cnt_o[1], 8'h01);
    chk("casc_hi1", 2, cnt_o[2], 8'h01);
    repeat (2) tick();
    chk("casc_hi0", 2, cnt_o[2], 8'h00);
    chk("casc_hi_done", 2, done_o[2], 8'h01);
    chk("casc_hi_exp", 2, exp_o[2], 8'h01);

    // Randomized traffic, including invalid digits, clears and async resets.
    repeat (3000) begin
      for (int i = 0; i < 3; i++) begin
        clrn_v[i] = ($urandom_range(31) != 0);
        load_v[i] = ($urandom_range(7) == 0);
        i_v[i] = ($urandom_range(3) == 0) ? 8'($urandom) : 8'($urandom_range(5));
        if (i < 2) en_v[i] = ($urandom_range(3) != 0);
      end
      if (!rstn) begin
        rstn = 1'b1;
      end else if ($urandom_range(199) == 0) begin
        #2 rstn = 1'b0;
        model_reset();
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
